// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: init FSM states, bus command encodings, address bit roles.
// Also used by the main SDRAM command FSM.
package sdram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StWaitRp,
    StRef,
    StWaitRfc,
    StMrs,
    StWaitMrd,
    StDone
  } init_state_e;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam int unsigned A10_IDX = 10;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sdram_cmd_timer.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module sdram_cmd_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sdram_init_sequencer.sv
// Drives PRECHARGE ALL, NUM_REFRESH x AUTO REFRESH and LOAD MODE REGISTER after an init
// request, then raises a sticky done flag. The state register names the command on the bus.
module sdram_init_sequencer
  import sdram_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH  = 13,
  parameter int unsigned             BA_WIDTH    = 2,
  parameter int unsigned             T_RP        = 2,
  parameter int unsigned             T_RFC       = 7,
  parameter int unsigned             T_MRD       = 2,
  parameter int unsigned             NUM_REFRESH = 2,
  parameter logic [ADDR_WIDTH-1:0]   MODE_REG    = 'h0032
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  init_start_i,
  output logic                  sdram_ready_o,
  output logic                  sdram_init_ack_o,
  output logic                  init_done_o,
  output logic                  sdr_cke_o,
  output logic                  sdr_cs_n_o,
  output logic                  sdr_ras_n_o,
  output logic                  sdr_cas_n_o,
  output logic                  sdr_we_n_o,
  output logic [ADDR_WIDTH-1:0] sdr_addr_o,
  output logic [BA_WIDTH-1:0]   sdr_ba_o
);

  localparam int unsigned   TW      = $clog2(max3(T_RP, T_RFC, T_MRD));
  localparam logic [TW-1:0] RP_LOAD  = TW'(T_RP - 1);
  localparam logic [TW-1:0] RFC_LOAD = TW'(T_RFC - 1);
  localparam logic [TW-1:0] MRD_LOAD = TW'(T_MRD - 1);
  localparam logic [3:0]    NUM_REF  = 4'(NUM_REFRESH);

  init_state_e           state_q;
  logic [3:0]            cmd_q;
  logic [3:0]            ref_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BA_WIDTH-1:0]   ba_q;
  logic                  ready_q;
  logic                  done_q;

  logic                  tmr_load;
  logic [TW-1:0]         tmr_val;
  logic                  tmr_zero;

  // The timer is loaded on the same edge the command is registered, so it counts the
  // command cycle itself.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      StIdle: begin
        tmr_load = init_start_i;
        tmr_val  = RP_LOAD;
      end
      StWaitRp: begin
        tmr_load = tmr_zero;
        tmr_val  = RFC_LOAD;
      end
      StWaitRfc: begin
        tmr_load = tmr_zero;
        tmr_val  = (ref_cnt_q < NUM_REF) ? RFC_LOAD : MRD_LOAD;
      end
      default: ;
    endcase
  end

  sdram_cmd_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q   <= StIdle;
      cmd_q     <= CMD_NOP;
      ref_cnt_q <= '0;
      addr_q    <= '0;
      ba_q      <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      cmd_q  <= CMD_NOP;
      addr_q <= '0;
      ba_q   <= '0;
      unique case (state_q)
        StIdle: begin
          if (init_start_i) begin
            state_q         <= StPre;
            ready_q         <= 1'b0;
            cmd_q           <= CMD_PRE;
            addr_q[A10_IDX] <= 1'b1;
          end
        end
        StPre: state_q <= StWaitRp;
        StWaitRp: begin
          if (tmr_zero) begin
            state_q   <= StRef;
            cmd_q     <= CMD_REF;
            ref_cnt_q <= ref_cnt_q + 4'd1;
          end
        end
        StRef: state_q <= StWaitRfc;
        StWaitRfc: begin
          if (tmr_zero) begin
            if (ref_cnt_q < NUM_REF) begin
              state_q   <= StRef;
              cmd_q     <= CMD_REF;
              ref_cnt_q <= ref_cnt_q + 4'd1;
            end else begin
              state_q <= StMrs;
              cmd_q   <= CMD_MRS;
              addr_q  <= MODE_REG;
            end
          end
        end
        StMrs: state_q <= StWaitMrd;
        StWaitMrd: begin
          if (tmr_zero) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sdram_init_ack_o = init_start_i && (state_q == StIdle);
  assign sdram_ready_o    = ready_q;
  assign init_done_o      = done_q;
  assign sdr_cke_o        = 1'b1;
  assign {sdr_cs_n_o, sdr_ras_n_o, sdr_cas_n_o, sdr_we_n_o} = cmd_q;
  assign sdr_addr_o       = addr_q;
  assign sdr_ba_o         = ba_q;

endmodule

// File: tb/tb_sdram_init_sequencer.sv
// Bench for sdram_init_sequencer: three instances (default, long refresh, minimum timing)
// checked against a directed vector table and a timing model built from the command schedule.
module tb_sdram_init_sequencer;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start = '0;
  logic [2:0]  ready, ack, done, cke, cs_n, ras_n, cas_n, we_n;
  logic [12:0] addr [3];
  logic [1:0]  ba   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_init_sequencer u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .init_start_i(start[0]),
    .sdram_ready_o(ready[0]), .sdram_init_ack_o(ack[0]), .init_done_o(done[0]),
    .sdr_cke_o(cke[0]), .sdr_cs_n_o(cs_n[0]), .sdr_ras_n_o(ras_n[0]),
    .sdr_cas_n_o(cas_n[0]), .sdr_we_n_o(we_n[0]), .sdr_addr_o(addr[0]), .sdr_ba_o(ba[0])
  );

  sdram_init_sequencer #(
    .T_RFC(9), .NUM_REFRESH(8)
  ) u_dut1 (
    .HCLK(clk), .HRESETn(rst_n), .init_start_i(start[1]),
    .sdram_ready_o(ready[1]), .sdram_init_ack_o(ack[1]), .init_done_o(done[1]),
    .sdr_cke_o(cke[1]), .sdr_cs_n_o(cs_n[1]), .sdr_ras_n_o(ras_n[1]),
    .sdr_cas_n_o(cas_n[1]), .sdr_we_n_o(we_n[1]), .sdr_addr_o(addr[1]), .sdr_ba_o(ba[1])
  );

  sdram_init_sequencer #(
    .T_RP(2), .T_RFC(2), .T_MRD(2), .NUM_REFRESH(1)
  ) u_dut2 (
    .HCLK(clk), .HRESETn(rst_n), .init_start_i(start[2]),
    .sdram_ready_o(ready[2]), .sdram_init_ack_o(ack[2]), .init_done_o(done[2]),
    .sdr_cke_o(cke[2]), .sdr_cs_n_o(cs_n[2]), .sdr_ras_n_o(ras_n[2]),
    .sdr_cas_n_o(cas_n[2]), .sdr_we_n_o(we_n[2]), .sdr_addr_o(addr[2]), .sdr_ba_o(ba[2])
  );

  // Packed view: {cmd[3:0], ready, done, ack, cke, ba[1:0], addr[12:0]}
  function automatic logic [22:0] obs(input int s);
    return {cs_n[s], ras_n[s], cas_n[s], we_n[s], ready[s], done[s], ack[s], cke[s],
            ba[s], addr[s]};
  endfunction

  function automatic logic [22:0] pack(input logic [3:0] cmd, input logic rdy,
                                       input logic dn, input logic ak,
                                       input logic [12:0] ad);
    return {cmd, rdy, dn, ak, 1'b1, 2'b00, ad};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Expected bus state in cycle c after acceptance, from the command schedule.
  function automatic logic [22:0] model(input int c, input int trp, input int trfc,
                                        input int tmrd, input int n);
    logic [3:0]  cmd;
    logic [12:0] ad;
    cmd = NOP;
    ad  = '0;
    if (c == 1) begin
      cmd = PRE;
      ad  = 13'h0400;
    end
    for (int k = 1; k <= n; k++) begin
      if (c == 1 + trp + (k - 1) * trfc) cmd = REF;
    end
    if (c == 1 + trp + n * trfc) begin
      cmd = MRS;
      ad  = 13'h0032;
    end
    return pack(cmd, 1'b0, (c >= 1 + trp + n * trfc + tmrd), 1'b0, ad);
  endfunction

  task automatic run_seq(input int s, input int trp, input int trfc, input int tmrd,
                         input int n, input int len, input string name);
    @(negedge clk);
    start[s] = 1'b1;
    #1 check($sformatf("%s_accept", name), obs(s), pack(NOP, 1'b1, 1'b0, 1'b1, 13'h0));
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      start[s] = 1'b0;
      #1 check($sformatf("%s_cyc%0d", name, c), obs(s), model(c, trp, trfc, tmrd, n));
    end
  endtask

  typedef struct {
    int          cyc;
    logic        start;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        ready;
    logic        done;
    logic        ack;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int idx;
    int n_ack, n_pre, n_ref, n_mrs;

    tbl[0]  = '{0,  1'b1, NOP, 13'h0000, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1,  1'b0, PRE, 13'h0400, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{2,  1'b0, NOP, 13'h0000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{3,  1'b0, REF, 13'h0000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{4,  1'b0, NOP, 13'h0000, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{9,  1'b0, NOP, 13'h0000, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{10, 1'b0, REF, 13'h0000, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{11, 1'b0, NOP, 13'h0000, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{16, 1'b0, NOP, 13'h0000, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{17, 1'b0, MRS, 13'h0032, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{18, 1'b0, NOP, 13'h0000, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{19, 1'b0, NOP, 13'h0000, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{20, 1'b1, NOP, 13'h0000, 1'b0, 1'b1, 1'b0};

    // Idle after reset on every instance
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      for (int s = 0; s < 3; s++)
        check($sformatf("idle_i%0d_c%0d", s, c), obs(s), pack(NOP, 1'b1, 1'b0, 1'b0, 13'h0));
    end

    // Default timing from the vector table; start in the last row is ignored in DONE
    idx = 0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      start[0] = (idx < 13 && tbl[idx].cyc == c) ? tbl[idx].start : 1'b0;
      #1;
      if (idx < 13 && tbl[idx].cyc == c) begin
        check($sformatf("vec_c%0d", c), obs(0),
              pack(tbl[idx].cmd, tbl[idx].ready, tbl[idx].done, tbl[idx].ack, tbl[idx].addr));
        idx++;
      end
    end
    start[0] = 1'b0;

    // Request held high: one ack, one sequence, no restart after DONE
    do_reset();
    n_ack = 0; n_pre = 0; n_ref = 0; n_mrs = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start[0] = (c < 30);
      #1;
      if (ack[0]) n_ack++;
      if ({cs_n[0], ras_n[0], cas_n[0], we_n[0]} == PRE) n_pre++;
      if ({cs_n[0], ras_n[0], cas_n[0], we_n[0]} == REF) n_ref++;
      if ({cs_n[0], ras_n[0], cas_n[0], we_n[0]} == MRS) n_mrs++;
    end
    check("hold_acks", n_ack, 1);
    check("hold_pre", n_pre, 1);
    check("hold_ref", n_ref, 2);
    check("hold_mrs", n_mrs, 1);
    check("hold_done", {ready[0], done[0]}, 2'b01);

    // Eight refreshes, tRFC = 9
    do_reset();
    run_seq(1, 2, 9, 2, 8, 80, "long");

    // Reset pulse inside WAIT_RFC, then a full replay
    do_reset();
    @(negedge clk);
    start[0] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midreset", obs(0), pack(NOP, 1'b1, 1'b0, 1'b0, 13'h0));
    run_seq(0, 2, 7, 2, 2, 22, "replay");

    // Minimum timing everywhere
    do_reset();
    run_seq(2, 2, 2, 2, 1, 10, "min");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
